alu_arbiter: RTL

- Shares the single 3-stage pipelined ALU between two requesters: requester 0 is the datapath control unit, requester 1 is the auxiliary/debug port.
- Round-robin arbitration, one issue per cycle, drives the ALU operand/opcode inputs.
- Tracks in-flight operations in a tag pipeline matched to ALU latency and returns each 64-bit result tagged with its requester ID.
- Keeps per-requester issue counters for performance monitoring.

---
 rtl/alu_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU between the control unit (0)
// and the debug port (1); returns tagged results and keeps issue counters.
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 3,
  parameter int unsigned CNT_W   = 16,
  parameter logic [4:0]  NOP_OP  = 5'b00000
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_A,
  input  logic [31:0]      req0_B,
  input  logic [4:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_A,
  input  logic [31:0]      req1_B,
  input  logic [4:0]       req1_op,
  output logic             alu_clear,
  output logic [31:0]      alu_A,
  output logic [31:0]      alu_B,
  output logic [4:0]       alu_opcode,
  input  logic [63:0]      alu_C,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [63:0]      resp_data,
  output logic [1:0]       in_flight,
  output logic [CNT_W-1:0] issue_cnt0,
  output logic [CNT_W-1:0] issue_cnt1
);

  logic               last_grant;
  logic               grant_any;
  logic               winner;
  logic [ALU_LAT-1:0] tag_v;
  logic [ALU_LAT-1:0] tag_id;
  logic [CNT_W-1:0]   cnt0;
  logic [CNT_W-1:0]   cnt1;

  always_comb begin
    grant_any = 1'b0;
    winner    = 1'b0;
    if (!clear) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        winner    = ~last_grant;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        winner    = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        winner    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any & ~winner;
  assign req1_ready = grant_any & winner;
  assign alu_clear  = clear;

  always_comb begin
    alu_A      = '0;
    alu_B      = '0;
    alu_opcode = NOP_OP;
    if (grant_any) begin
      alu_A      = winner ? req1_A  : req0_A;
      alu_B      = winner ? req1_B  : req0_B;
      alu_opcode = winner ? req1_op : req0_op;
    end
  end

  // Tag pipeline mirrors the ALU stages so the last tag lines up with C_reg.
  always_ff @(posedge clk) begin
    if (clear) begin
      tag_v      <= '0;
      tag_id     <= '0;
      last_grant <= 1'b1;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      tag_v[0]  <= grant_any;
      tag_id[0] <= winner;
      for (int unsigned i = 1; i < ALU_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      if (grant_any) begin
        last_grant <= winner;
        if (winner) cnt1 <= cnt1 + 1'b1;
        else        cnt0 <= cnt0 + 1'b1;
      end
    end
  end

  // Results landing in a clear cycle belong to flushed ops and are suppressed.
  assign resp_valid = tag_v[ALU_LAT-1] & ~clear;
  assign resp_id    = resp_valid & tag_id[ALU_LAT-1];
  assign resp_data  = resp_valid ? alu_C : '0;

  always_comb begin
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < ALU_LAT; i++) begin
      n = n + 32'(tag_v[i]);
    end
    in_flight = 2'(n);
  end

  assign issue_cnt0 = cnt0;
  assign issue_cnt1 = cnt1;

endmodule
